// File: rtl/mult_stream_accumulator.sv
// rtl/mult_stream_accumulator.sv - aligns the multiplier product stream with its valid/last flags
// and accumulates saturating unsigned dot products into a valid/ready result register.
module mult_stream_accumulator #(
  parameter int LATENCY = 5,
  parameter int MULT_W  = 36,
  parameter int ACC_W   = 48,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              in_valid_i,
  input  logic              in_last_i,
  input  logic [MULT_W-1:0] mult_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [ACC_W-1:0]  result_o,
  output logic [CNT_W-1:0]  res_cnt_o,
  output logic              res_sat_o,
  output logic              err_overrun_o
);

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e             state_q, state_d;
  logic [LATENCY-1:0] vld_q, lst_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic [ACC_W-1:0]   result_q;
  logic [CNT_W-1:0]   res_cnt_q;
  logic               res_sat_q;
  logic               res_valid_q;
  logic               err_q;

  logic               v_al, l_al, complete, xfer;
  logic [ACC_W-1:0]   acc_base;
  logic [CNT_W-1:0]   cnt_base;
  logic [ACC_W:0]     sum_full;

  assign v_al     = vld_q[LATENCY-1];
  assign l_al     = lst_q[LATENCY-1];
  assign complete = v_al & l_al & ~clr_i;
  assign xfer     = res_valid_q & res_ready_i;

  // One extra sum bit exposes overflow so the accumulator can clamp instead of wrapping.
  always_comb begin
    acc_base = (state_q == ACCUM) ? acc_q : '0;
    cnt_base = (state_q == ACCUM) ? cnt_q : '0;
    sum_full = {1'b0, acc_base} + {{(ACC_W + 1 - MULT_W){1'b0}}, mult_i};
    acc_d    = sum_full[ACC_W] ? '1 : sum_full[ACC_W-1:0];
    cnt_d    = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
    sat_d    = ((state_q == ACCUM) & sat_q) | sum_full[ACC_W] | (&cnt_base);
    state_d  = l_al ? IDLE : ACCUM;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q       <= '0;
      lst_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      state_q     <= IDLE;
      result_q    <= '0;
      res_cnt_q   <= '0;
      res_sat_q   <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (clr_i) begin
        vld_q   <= '0;
        lst_q   <= '0;
        acc_q   <= '0;
        cnt_q   <= '0;
        sat_q   <= 1'b0;
        state_q <= IDLE;
      end else begin
        vld_q[0] <= in_valid_i;
        lst_q[0] <= in_valid_i & in_last_i;
        for (int i = 1; i < LATENCY; i++) begin
          vld_q[i] <= vld_q[i-1];
          lst_q[i] <= lst_q[i-1];
        end
        if (v_al) begin
          acc_q   <= acc_d;
          cnt_q   <= cnt_d;
          sat_q   <= sat_d;
          state_q <= state_d;
        end
      end

      // The output register is left alone by clr_i; a completion only lands if the slot frees up.
      if (complete && (!res_valid_q || res_ready_i)) begin
        result_q    <= acc_d;
        res_cnt_q   <= cnt_d;
        res_sat_q   <= sat_d;
        res_valid_q <= 1'b1;
      end else if (xfer) begin
        res_valid_q <= 1'b0;
      end

      if (complete && res_valid_q && !res_ready_i) begin
        err_q <= 1'b1;
      end
    end
  end

  assign res_valid_o   = res_valid_q;
  assign result_o      = result_q;
  assign res_cnt_o     = res_cnt_q;
  assign res_sat_o     = res_sat_q;
  assign err_overrun_o = err_q;

endmodule

// File: tb/tb_mult_stream_accumulator.sv
// tb/tb_mult_stream_accumulator.sv - scoreboard bench for mult_stream_accumulator with a modelled
// five-stage multiplier; a second instance with a 36-bit accumulator covers saturation.
`timescale 1ns/100ps
module tb_mult_stream_accumulator;
  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        res_ready = 1'b1;
  logic [17:0] a = '0;
  logic [17:0] b = '0;
  logic [35:0] mult;
  logic [35:0] pipe [LAT];

  logic        rv1, sat1, err1;
  logic [47:0] res1;
  logic [15:0] cnt1;
  logic        rv2, sat2, err2;
  logic [35:0] res2;
  logic [15:0] cnt2;

  typedef struct packed {
    logic [47:0] r;
    logic [15:0] c;
    logic        s;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   n;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe[0] <= 36'(a) * 36'(b);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mult = pipe[LAT-1];

  mult_stream_accumulator #(.LATENCY(LAT), .MULT_W(36), .ACC_W(48), .CNT_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .in_valid_i(in_valid), .in_last_i(in_last),
    .mult_i(mult), .res_valid_o(rv1), .res_ready_i(res_ready), .result_o(res1),
    .res_cnt_o(cnt1), .res_sat_o(sat1), .err_overrun_o(err1)
  );

  mult_stream_accumulator #(.LATENCY(LAT), .MULT_W(36), .ACC_W(36), .CNT_W(16)) dut36 (
    .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .in_valid_i(in_valid), .in_last_i(in_last),
    .mult_i(mult), .res_valid_o(rv2), .res_ready_i(res_ready), .result_o(res2),
    .res_cnt_o(cnt2), .res_sat_o(sat2), .err_overrun_o(err2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic term(input logic [17:0] ta, input logic [17:0] tb, input logic l);
    a = ta; b = tb; in_valid = 1'b1; in_last = l;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cycles);
    cycles = 0;
    while (!rv1 && cycles < budget) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++;
    if ({rv1, res1, cnt1, sat1, err1} !== '0)
      begin errors++; $display("FAIL reset_dut48: got v=%0b r=%0d c=%0d s=%0b e=%0b, want all 0", rv1, res1, cnt1, sat1, err1); end
    checks++;
    if ({rv2, res2, cnt2, sat2, err2} !== '0)
      begin errors++; $display("FAIL reset_dut36: got v=%0b r=%0d c=%0d s=%0b e=%0b, want all 0", rv2, res2, cnt2, sat2, err2); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    sb.push_back('{48'd98, 16'd3, 1'b0});
    term(3, 4, 0); term(5, 6, 0); term(7, 8, 1);
    wait_valid(20, n);
    checks++;
    if (n !== LAT) begin errors++; $display("FAIL single_latency: got %0d cycles, want %0d", n, LAT); end
    e = sb.pop_front();
    checks++;
    if ({res1, cnt1, sat1} !== e)
      begin errors++; $display("FAIL single_result: got r=%0d c=%0d s=%0b, want r=%0d c=%0d s=%0b", res1, cnt1, sat1, e.r, e.c, e.s); end
    step();
    checks++;
    if (rv1 !== 1'b0) begin errors++; $display("FAIL single_pulse: res_valid=%0b, want 0", rv1); end
  endtask

  task automatic test_back_to_back();
    sb.push_back('{48'd4, 16'd1, 1'b0});
    sb.push_back('{48'd9, 16'd1, 1'b0});
    term(2, 2, 1); term(3, 3, 1);
    wait_valid(20, n);
    e = sb.pop_front();
    checks++;
    if (!rv1 || {res1, cnt1, sat1} !== e)
      begin errors++; $display("FAIL b2b_first: got v=%0b r=%0d c=%0d, want v=1 r=%0d c=%0d", rv1, res1, cnt1, e.r, e.c); end
    step();
    e = sb.pop_front();
    checks++;
    if (!rv1 || {res1, cnt1, sat1} !== e)
      begin errors++; $display("FAIL b2b_second: got v=%0b r=%0d c=%0d, want v=1 r=%0d c=%0d", rv1, res1, cnt1, e.r, e.c); end
    step();
    checks++;
    if (rv1 !== 1'b0) begin errors++; $display("FAIL b2b_drop: res_valid=%0b, want 0", rv1); end
  endtask

  task automatic test_overrun();
    res_ready = 1'b0;
    sb.push_back('{48'd100, 16'd1, 1'b0});
    term(10, 10, 1); term(20, 20, 1);
    wait_valid(20, n);
    checks++;
    if (err1 !== 1'b0) begin errors++; $display("FAIL overrun_early: err=%0b, want 0", err1); end
    repeat (3) step();
    checks++;
    if (err1 !== 1'b1 || rv1 !== 1'b1)
      begin errors++; $display("FAIL overrun_flag: got err=%0b v=%0b, want err=1 v=1", err1, rv1); end
    res_ready = 1'b1;
    e = sb.pop_front();
    checks++;
    if ({res1, cnt1, sat1} !== e)
      begin errors++; $display("FAIL overrun_held: got r=%0d c=%0d, want r=%0d c=%0d", res1, cnt1, e.r, e.c); end
    step();
    checks++;
    if (rv1 !== 1'b0 || err1 !== 1'b1)
      begin errors++; $display("FAIL overrun_after: got v=%0b err=%0b, want v=0 err=1", rv1, err1); end
  endtask

  task automatic test_saturation();
    sb.push_back('{48'd137437904898, 16'd2, 1'b0});
    sb.push_back('{48'd1, 16'd1, 1'b0});
    term(18'd262143, 18'd262143, 0); term(18'd262143, 18'd262143, 1);
    wait_valid(20, n);
    e = sb.pop_front();
    checks++;
    if (!rv1 || {res1, cnt1, sat1} !== e)
      begin errors++; $display("FAIL sat_wide: got v=%0b r=%0d c=%0d s=%0b, want r=%0d c=%0d s=%0b", rv1, res1, cnt1, sat1, e.r, e.c, e.s); end
    checks++;
    if (!rv2 || {res2, cnt2, sat2} !== {36'hF_FFFF_FFFF, 16'd2, 1'b1})
      begin errors++; $display("FAIL sat_clamp: got v=%0b r=%0d c=%0d s=%0b, want r=68719476735 c=2 s=1", rv2, res2, cnt2, sat2); end
    step();
    term(1, 1, 1);
    wait_valid(20, n);
    e = sb.pop_front();
    checks++;
    if (!rv1 || {res1, cnt1, sat1} !== e)
      begin errors++; $display("FAIL sat_next_wide: got r=%0d c=%0d s=%0b, want r=%0d c=%0d s=%0b", res1, cnt1, sat1, e.r, e.c, e.s); end
    checks++;
    if (!rv2 || {res2, cnt2, sat2} !== {36'd1, 16'd1, 1'b0})
      begin errors++; $display("FAIL sat_restart: got v=%0b r=%0d c=%0d s=%0b, want r=1 c=1 s=0", rv2, res2, cnt2, sat2); end
    step();
  endtask

  task automatic test_clr();
    sb.push_back('{48'd1, 16'd1, 1'b0});
    term(9, 9, 0);
    repeat (LAT + 1) step();
    checks++;
    if (rv1 !== 1'b0) begin errors++; $display("FAIL clr_partial: res_valid=%0b, want 0", rv1); end
    a = 5; b = 5; in_valid = 1'b1; clr = 1'b1;
    step();
    in_valid = 1'b0; clr = 1'b0;
    term(1, 1, 1);
    wait_valid(20, n);
    e = sb.pop_front();
    checks++;
    if (!rv1 || {res1, cnt1, sat1} !== e)
      begin errors++; $display("FAIL clr_result: got v=%0b r=%0d c=%0d, want r=%0d c=%0d", rv1, res1, cnt1, e.r, e.c); end
    step();
  endtask

  task automatic test_async_reset();
    res_ready = 1'b0;
    term(3, 3, 1);
    repeat (LAT + 1) step();
    checks++;
    if (rv1 !== 1'b1 || res1 !== 48'd9 || err1 !== 1'b1)
      begin errors++; $display("FAIL areset_pre: got v=%0b r=%0d err=%0b, want v=1 r=9 err=1", rv1, res1, err1); end
    term(6, 6, 0);
    step();
    #2 rst_n = 1'b0;
    #0.5;
    checks++;
    if ({rv1, res1, cnt1, sat1, err1} !== '0)
      begin errors++; $display("FAIL areset_now: got v=%0b r=%0d c=%0d s=%0b e=%0b, want all 0", rv1, res1, cnt1, sat1, err1); end
    #0.5 rst_n = 1'b1;
    res_ready = 1'b1;
    sb.push_back('{48'd42, 16'd1, 1'b0});
    step();
    term(6, 7, 1);
    wait_valid(20, n);
    e = sb.pop_front();
    checks++;
    if (!rv1 || {res1, cnt1, sat1} !== e)
      begin errors++; $display("FAIL areset_after: got v=%0b r=%0d c=%0d, want r=%0d c=%0d", rv1, res1, cnt1, e.r, e.c); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_saturation();
    test_clr();
    test_async_reset();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_empty: %0d left, want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
